// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply sequencer.
package matmul_pkg;
  typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;

  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n * n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int ptr_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/matrix_mult_sequencer_mac_unit.sv
// Single multiply-accumulate lane: combinational a*b + acc, registered accumulator.
module mac_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_prod;

  // Products and sums wrap modulo 2^WIDTH by truncation.
  assign w_prod = i_a * i_b;
  assign o_sum  = r_acc + w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= o_sum;
  end
endmodule

// File: rtl/matrix_mult_sequencer.sv
// Loads A then B as a serial stream, then emits C = A*B row-major, one MAC per cycle.
module matrix_mult_sequencer
  import matmul_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MATRIX_DIMS = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic [idx_w(MATRIX_DIMS)-1:0]     out_index,
  output logic                              out_last,
  output logic                              busy
);
  localparam int N  = MATRIX_DIMS;
  localparam int NN = N * N;
  localparam int IW = idx_w(N);
  localparam int PW = ptr_w(N);
  localparam int LW = IW + 1;

  state_t           r_state, w_next;
  logic [LW-1:0]    r_load_cnt;
  logic [PW-1:0]    r_row, r_col, r_k;
  logic             r_out_valid, r_out_last;
  logic [WIDTH-1:0] r_out_data;
  logic [IW-1:0]    r_out_index;
  logic [WIDTH-1:0] r_mat_a [NN];
  logic [WIDTH-1:0] r_mat_b [NN];

  logic             w_in_fire, w_load_done, w_k_last, w_mac_en, w_mac_clr;
  logic [IW-1:0]    w_a_idx, w_b_idx;
  logic [WIDTH-1:0] w_sum;

  assign w_in_fire   = in_valid && (r_state == LOAD);
  assign w_load_done = w_in_fire && (r_load_cnt == LW'(2 * NN - 1));
  assign w_k_last    = (r_k == PW'(N - 1));
  assign w_a_idx     = IW'(r_row) * IW'(N) + IW'(r_k);
  assign w_b_idx     = IW'(r_k) * IW'(N) + IW'(r_col);

  mac_unit #(.WIDTH(WIDTH)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_mac_en),
    .i_clr (w_mac_clr),
    .i_a   (r_mat_a[w_a_idx]),
    .i_b   (r_mat_b[w_b_idx]),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_mac_en  = 1'b0;
    w_mac_clr = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_load_done) begin
          w_next    = COMPUTE;
          w_mac_clr = 1'b1;
        end
      end
      COMPUTE: begin
        w_mac_en = 1'b1;
        if (w_k_last) begin
          w_mac_clr = 1'b1;
          w_next    = OUT;
        end
      end
      OUT: begin
        if (out_ready) w_next = r_out_last ? LOAD : COMPUTE;
      end
      default: w_next = LOAD;
    endcase
  end

  // Operand storage keeps its contents across reset; only the load counter restarts.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      if (r_load_cnt < LW'(NN)) r_mat_a[r_load_cnt[IW-1:0]] <= in_data;
      else                      r_mat_b[IW'(r_load_cnt - LW'(NN))] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt  <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_fire) r_load_cnt <= w_load_done ? '0 : r_load_cnt + LW'(1);
          if (w_load_done) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
          end
        end
        COMPUTE: begin
          r_k <= w_k_last ? '0 : r_k + PW'(1);
          if (w_k_last) begin
            r_out_data  <= w_sum;
            r_out_index <= IW'(r_row) * IW'(N) + IW'(r_col);
            r_out_last  <= (r_row == PW'(N - 1)) && (r_col == PW'(N - 1));
            r_out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_load_cnt <= '0;
            end else if (r_col == PW'(N - 1)) begin
              r_col <= '0;
              r_row <= r_row + PW'(1);
            end else begin
              r_col <= r_col + PW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == LOAD);
  assign busy      = (r_state != LOAD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Randomized and directed bench for matrix_mult_sequencer (N=3, WIDTH=32) against a plain matrix-product model.
module tb_matrix_mult_sequencer;
  localparam int W  = 32;
  localparam int N  = 3;
  localparam int NN = N * N;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;

  matrix_mult_sequencer #(.WIDTH(W), .MATRIX_DIMS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] ma [NN];
  logic [W-1:0] mb [NN];
  logic [W-1:0] exp_c [NN];
  logic [W-1:0] got_data [NN];
  int           got_idx [NN];
  bit           got_last [NN];
  int           rise_e [NN];
  int           got_cnt, stable_bad, inrdy_bad;

  task automatic build_model();
    logic [W-1:0] s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) s = s + ma[i*N+k] * mb[k*N+j];
        exp_c[i*N+j] = s;
      end
  endtask

  task automatic load_mats();
    for (int i = 0; i < 2 * NN; i++) begin
      in_valid = 1'b1;
      in_data  = (i < NN) ? ma[i] : mb[i-NN];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Gathers handshaken outputs; edge counts are relative to the final load transfer.
  task automatic collect(input int stall_idx, input int stall_n, input bit stray, input bit rand_ready);
    int edges, stalled;
    bit prev_valid;
    logic [W-1:0] cap_d;
    logic [IW-1:0] cap_i;
    logic cap_l;
    edges = 0; stalled = 0; prev_valid = 0;
    got_cnt = 0; stable_bad = 0; inrdy_bad = 0;
    cap_d = '0; cap_i = '0; cap_l = 0;
    out_ready = 1'b1;
    while (got_cnt < NN && edges < 400) begin
      @(posedge clk);
      edges++;
      #1;
      if (out_valid && !prev_valid) begin
        rise_e[got_cnt] = edges;
        cap_d = out_data; cap_i = out_index; cap_l = out_last;
      end else if (out_valid && prev_valid) begin
        if (out_data !== cap_d || out_index !== cap_i || out_last !== cap_l) stable_bad++;
      end
      if (busy && in_ready) inrdy_bad++;
      if (out_valid && out_index == stall_idx && stalled < stall_n) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid && out_ready) begin
        got_data[got_cnt] = out_data;
        got_idx[got_cnt]  = int'(out_index);
        got_last[got_cnt] = out_last;
        got_cnt++;
      end
      if (stray) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      prev_valid = out_valid;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic set_ident_seq(input logic [W-1:0] diag);
    for (int i = 0; i < NN; i++) begin
      ma[i] = (i % (N + 1) == 0) ? diag : '0;
      mb[i] = W'(i + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    n_cmp++; if (out_index !== '0) begin n_err++; $display("FAIL reset_out_index got=%0d want=0", out_index); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_identity();
    set_ident_seq(W'(1));
    load_mats();
    collect(-1, 0, 1'b0, 1'b0);
    n_cmp++; if (got_cnt != NN) begin n_err++; $display("FAIL ident_count got=%0d want=%0d", got_cnt, NN); end
    n_cmp++; if (rise_e[0] != N) begin n_err++; $display("FAIL ident_latency got=%0d want=%0d", rise_e[0], N); end
    for (int i = 0; i < got_cnt; i++) begin
      n_cmp++;
      if (got_data[i] !== W'(i + 1) || got_idx[i] != i || got_last[i] != (i == NN - 1)) begin
        n_err++;
        $display("FAIL ident_elem%0d got=%0d/idx%0d/last%0d want=%0d/idx%0d/last%0d",
                 i, got_data[i], got_idx[i], got_last[i], i + 1, i, (i == NN - 1));
      end
    end
  endtask

  task automatic test_const();
    for (int i = 0; i < NN; i++) begin ma[i] = W'(2); mb[i] = W'(3); end
    load_mats();
    collect(-1, 0, 1'b0, 1'b0);
    n_cmp++; if (got_cnt != NN) begin n_err++; $display("FAIL const_count got=%0d want=%0d", got_cnt, NN); end
    for (int i = 0; i < got_cnt; i++) begin
      n_cmp++;
      if (got_data[i] !== W'(18) || got_idx[i] != i) begin
        n_err++; $display("FAIL const_elem%0d got=%0d idx%0d want=18 idx%0d", i, got_data[i], got_idx[i], i);
      end
      if (i > 0) begin
        n_cmp++;
        if (rise_e[i] - rise_e[i-1] != N + 1) begin
          n_err++; $display("FAIL const_gap%0d got=%0d want=%0d", i, rise_e[i] - rise_e[i-1], N + 1);
        end
      end
    end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL const_idle busy=%b in_ready=%b want busy=0 in_ready=1", busy, in_ready);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < NN; i++) begin ma[i] = 32'hFFFF_FFFF; mb[i] = W'(1); end
    load_mats();
    collect(-1, 0, 1'b0, 1'b0);
    n_cmp++; if (got_cnt != NN) begin n_err++; $display("FAIL wrap_count got=%0d want=%0d", got_cnt, NN); end
    for (int i = 0; i < got_cnt; i++) begin
      n_cmp++;
      if (got_data[i] !== 32'hFFFF_FFFD) begin
        n_err++; $display("FAIL wrap_elem%0d got=%h want=fffffffd", i, got_data[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_ident_seq(W'(1));
    load_mats();
    collect(4, 5, 1'b0, 1'b0);
    n_cmp++; if (got_cnt != NN) begin n_err++; $display("FAIL bp_count got=%0d want=%0d", got_cnt, NN); end
    n_cmp++; if (stable_bad != 0) begin n_err++; $display("FAIL bp_stable got=%0d want=0", stable_bad); end
    n_cmp++; if (inrdy_bad != 0) begin n_err++; $display("FAIL bp_in_ready got=%0d want=0", inrdy_bad); end
    n_cmp++; if (got_cnt == NN && rise_e[5] - rise_e[4] != N + 1 + 5) begin
      n_err++; $display("FAIL bp_stall_gap got=%0d want=%0d", rise_e[5] - rise_e[4], N + 6);
    end
    for (int i = 0; i < got_cnt; i++) begin
      n_cmp++;
      if (got_data[i] !== W'(i + 1) || got_idx[i] != i) begin
        n_err++; $display("FAIL bp_elem%0d got=%0d idx%0d want=%0d idx%0d", i, got_data[i], got_idx[i], i + 1, i);
      end
    end
  endtask

  task automatic test_stray();
    set_ident_seq(W'(1));
    load_mats();
    collect(-1, 0, 1'b1, 1'b0);
    n_cmp++; if (got_cnt != NN) begin n_err++; $display("FAIL stray_count got=%0d want=%0d", got_cnt, NN); end
    for (int i = 0; i < got_cnt; i++) begin
      n_cmp++;
      if (got_data[i] !== W'(i + 1) || got_idx[i] != i) begin
        n_err++; $display("FAIL stray_elem%0d got=%0d idx%0d want=%0d idx%0d", i, got_data[i], got_idx[i], i + 1, i);
      end
    end
  endtask

  task automatic test_mid_reset();
    int waited;
    bit seen;
    set_ident_seq(W'(1));
    load_mats();
    waited = 0; seen = 0;
    while (!seen && waited < 100) begin
      @(posedge clk);
      waited++;
      #1;
      if (out_valid && out_index == 1) seen = 1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL mreset_reach got=0 want=1"); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mreset_clear got v=%b d=%h i=%0d busy=%b rdy=%b want 0/0/0/0/1",
               out_valid, out_data, out_index, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_ident_seq(W'(2));
    load_mats();
    collect(-1, 0, 1'b0, 1'b0);
    n_cmp++; if (got_cnt != NN) begin n_err++; $display("FAIL mreset_count got=%0d want=%0d", got_cnt, NN); end
    for (int i = 0; i < got_cnt; i++) begin
      n_cmp++;
      if (got_data[i] !== W'(2 * (i + 1)) || got_idx[i] != i) begin
        n_err++; $display("FAIL mreset_elem%0d got=%0d idx%0d want=%0d idx%0d", i, got_data[i], got_idx[i], 2 * (i + 1), i);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NN; i++) begin
        ma[i] = (r == 0) ? W'($urandom_range(0, 255)) : $urandom;
        mb[i] = (r == 0) ? W'($urandom_range(0, 255)) : $urandom;
      end
      build_model();
      load_mats();
      collect(-1, 0, 1'b1, 1'b1);
      n_cmp++; if (got_cnt != NN) begin n_err++; $display("FAIL rand%0d_count got=%0d want=%0d", r, got_cnt, NN); end
      n_cmp++; if (stable_bad != 0) begin n_err++; $display("FAIL rand%0d_stable got=%0d want=0", r, stable_bad); end
      for (int i = 0; i < got_cnt; i++) begin
        n_cmp++;
        if (got_data[i] !== exp_c[i] || got_idx[i] != i || got_last[i] != (i == NN - 1)) begin
          n_err++;
          $display("FAIL rand%0d_elem%0d got=%h idx%0d last%0d want=%h idx%0d last%0d",
                   r, i, got_data[i], got_idx[i], got_last[i], exp_c[i], i, (i == NN - 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_const();
    test_wrap();
    test_backpressure();
    test_stray();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
